multicycle_decoder: RTL

- Control unit for the multicycle ARM-subset datapath; replaces the single-cycle main/ALU decoder with a Moore FSM sequencing fetch, decode, execute, memory and writeback over multiple cycles.
- Adds memory-ready stalling, a bounded wait timeout, and gating of all architectural writes by the condition-check result.
- Sits between the instruction register / condition logic and the shared-memory multicycle datapath.

---
 rtl/multicycle_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_decoder.sv
// multicycle_decoder: Moore FSM control unit for the multicycle ARM-subset datapath.
// Optional: define DECODER_EXT_OPS_EN to add EOR, MOV and CMP to the ALU decode.
module multicycle_decoder #(
    parameter int ALUCTRL_W  = 4,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 CondEx,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemW,
    output logic                 RegW,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 bus_err,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd15
    } state_t;

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_LIMIT);

    state_t        state;
    state_t        next;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout;
    logic          rd15;
    logic [2:0]    alu_ctl;
    logic [2:0]    alu_sel;
    logic          alu_ok;
    logic          alu_arith;
    logic          alu_cmp;
    logic [1:0]    flagw_alu;
    logic [1:0]    regsrc_op;
    logic [1:0]    immsrc_op;

    assign rd15    = (Rd == 4'd15);
    assign waiting = ((state == FETCH) || (state == MEMRD) ||
                      (state == MEMWR)) && !mem_ready;
    assign timeout = (WAIT_LIMIT > 0) && waiting && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next;
            if (waiting && !timeout) begin
                if (wait_cnt != '1)
                    wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Data-processing command decode; illegal commands send the FSM to UNKNOWN
    always_comb begin
        alu_ctl   = 3'd0;
        alu_ok    = 1'b1;
        alu_arith = 1'b0;
        alu_cmp   = 1'b0;
        case (Funct[4:1])
            4'b0100: begin alu_ctl = 3'd0; alu_arith = 1'b1; end
            4'b0010: begin alu_ctl = 3'd1; alu_arith = 1'b1; end
            4'b0000: alu_ctl = 3'd2;
            4'b1100: alu_ctl = 3'd3;
`ifdef DECODER_EXT_OPS_EN
            4'b0001: alu_ctl = 3'd4;
            4'b1101: alu_ctl = 3'd5;
            4'b1010: begin
                alu_ctl   = Funct[0] ? 3'd1 : 3'd0;
                alu_ok    = Funct[0];
                alu_arith = 1'b1;
                alu_cmp   = 1'b1;
            end
`endif
            default: alu_ok = 1'b0;
        endcase
    end

    assign flagw_alu = alu_ok ? {Funct[0] & CondEx, Funct[0] & CondEx & alu_arith}
                              : 2'b00;

    always_comb begin
        regsrc_op = 2'b00;
        immsrc_op = 2'b00;
        case (Op)
            2'b01: begin regsrc_op = {~Funct[0], 1'b0}; immsrc_op = 2'b01; end
            2'b10: begin regsrc_op = 2'b01; immsrc_op = 2'b10; end
            default: ;
        endcase
    end

    always_comb begin
        next = state;
        case (state)
            FETCH:   next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                unique case (1'b1)
                    (Op == 2'b01):              next = MEMADR;
                    (Op == 2'b00) && Funct[5]:  next = EXECI;
                    (Op == 2'b00) && !Funct[5]: next = EXECR;
                    (Op == 2'b10):              next = BRANCH;
                    default:                    next = UNKNOWN;
                endcase
            end
            MEMADR:  next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   next = mem_ready ? FETCH : MEMWR;
            MEMWB:   next = FETCH;
            EXECR:   next = alu_ok ? ALUWB : UNKNOWN;
            EXECI:   next = alu_ok ? ALUWB : UNKNOWN;
            ALUWB:   next = FETCH;
            BRANCH:  next = FETCH;
            UNKNOWN: next = UNKNOWN;
            default: next = UNKNOWN;
        endcase
        // A stalled access is abandoned and the same PC refetched
        if (timeout)
            next = FETCH;
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemW      = 1'b0;
        RegW      = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ImmSrc    = 2'b00;
        RegSrc    = 2'b00;
        alu_sel   = 3'd0;
        FlagW     = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = regsrc_op;
                ImmSrc    = immsrc_op;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
                RegSrc  = regsrc_op;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = CondEx;
                PCWrite   = CondEx & rd15;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                RegSrc = regsrc_op;
                MemW   = CondEx & !timeout;
            end
            EXECR: begin
                alu_sel = alu_ctl;
                FlagW   = flagw_alu;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_sel = alu_ctl;
                FlagW   = flagw_alu;
            end
            ALUWB: begin
                RegW    = CondEx & !alu_cmp;
                PCWrite = CondEx & !alu_cmp & rd15;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                RegSrc    = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = CondEx;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite = 1'b0;
            IRWrite = 1'b0;
            MemW    = 1'b0;
            RegW    = 1'b0;
            FlagW   = 2'b00;
        end
    end

    assign bus_err    = timeout & ~reset;
    assign ALUControl = {{(ALUCTRL_W-3){1'b0}}, alu_sel};
    assign state_o    = state;

endmodule
